// File: rtl/case_mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control.
// The result is optionally truncated or saturated to dout_WIDTH.
module case_mul_pipe_hs #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 14,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 26,
    parameter int SAT        = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  signed_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int P  = din0_WIDTH + din1_WIDTH;
    localparam int DW = dout_WIDTH;

    if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_num_stage
        $error("case_mul_pipe_hs ID=%0d: NUM_STAGE must be in 1..8", ID);
    end

    // Handshake: a beat moves on a side when valid && ready are both high at a
    // rising edge. The whole pipe advances as one (en); when the output beat is
    // waiting for out_ready every stage holds and in_ready drops in the same cycle.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic [P-1:0] a_x, b_x, prod_in;

    // Operands extended to P bits make the modulo-2^P product exact for both modes.
    always_comb begin
        if (signed_mode) begin
            a_x = {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0};
            b_x = {{din0_WIDTH{din1[din1_WIDTH-1]}}, din1};
        end else begin
            a_x = {{din1_WIDTH{1'b0}}, din0};
            b_x = {{din0_WIDTH{1'b0}}, din1};
        end
        prod_in = a_x * b_x;
    end

    logic [NUM_STAGE-1:0] v;
    logic [NUM_STAGE-1:0] md;
    logic [P-1:0]         pr [NUM_STAGE];

    // Data registers load only behind a valid beat so dout holds its reset value
    // until the first result arrives.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            v  <= '0;
            md <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                pr[i] <= '0;
            end
        end else if (en) begin
            v[0] <= in_valid;
            if (in_valid) begin
                pr[0] <= prod_in;
                md[0] <= signed_mode;
            end
            for (int i = 1; i < NUM_STAGE; i++) begin
                v[i] <= v[i-1];
                if (v[i-1]) begin
                    pr[i] <= pr[i-1];
                    md[i] <= md[i-1];
                end
            end
        end
    end

    logic [P-1:0] pr_last;
    logic         md_last;

    assign out_valid = v[NUM_STAGE-1];
    assign pr_last   = pr[NUM_STAGE-1];
    assign md_last   = md[NUM_STAGE-1];

    if (DW >= P) begin : g_wide
        always_comb begin
            if (md_last) begin
                dout = DW'($signed(pr_last));
            end else begin
                dout = DW'(pr_last);
            end
            ovf = 1'b0;
        end
    end else begin : g_narrow
        localparam logic [DW-1:0] SMAX = {DW{1'b1}} >> 1;
        logic fit;

        // Signed results fit when the dropped bits all copy dout's MSB.
        always_comb begin
            if (md_last) begin
                fit = (pr_last[P-1:DW-1] == '0) || (pr_last[P-1:DW-1] == '1);
            end else begin
                fit = (pr_last[P-1:DW] == '0);
            end
            ovf  = !fit;
            dout = pr_last[DW-1:0];
            if (SAT != 0 && !fit) begin
                if (!md_last) begin
                    dout = '1;
                end else if (pr_last[P-1]) begin
                    dout = ~SMAX;
                end else begin
                    dout = SMAX;
                end
            end
        end
    end

endmodule

// File: tb/tb_case_mul_pipe_hs.sv
// Directed bench: three 2-stage width/saturation variants share one stimulus,
// a 3-stage instance covers back-pressure and mid-flight reset.
module tb_case_mul_pipe_hs;

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    always #5 ap_clk = ~ap_clk;

    logic       in_valid, out_ready, signed_mode;
    logic [3:0] din0;
    logic [2:0] din1;
    logic       a_in_ready, a_out_valid, a_ovf;
    logic [6:0] a_dout;
    logic       b_in_ready, b_out_valid, b_ovf;
    logic [4:0] b_dout;
    logic       c_in_ready, c_out_valid, c_ovf;
    logic [4:0] c_dout;

    logic       d_in_valid, d_out_ready, d_signed_mode;
    logic [3:0] d_din0;
    logic [2:0] d_din1;
    logic       d_in_ready, d_out_valid, d_ovf;
    logic [6:0] d_dout;

    case_mul_pipe_hs #(.ID(1), .NUM_STAGE(2), .din0_WIDTH(4), .din1_WIDTH(3),
                       .dout_WIDTH(7), .SAT(0)) u_a (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .din0(din0), .din1(din1), .signed_mode(signed_mode), .out_valid(a_out_valid),
        .out_ready(out_ready), .dout(a_dout), .ovf(a_ovf));

    case_mul_pipe_hs #(.ID(2), .NUM_STAGE(2), .din0_WIDTH(4), .din1_WIDTH(3),
                       .dout_WIDTH(5), .SAT(0)) u_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .din0(din0), .din1(din1), .signed_mode(signed_mode), .out_valid(b_out_valid),
        .out_ready(out_ready), .dout(b_dout), .ovf(b_ovf));

    case_mul_pipe_hs #(.ID(3), .NUM_STAGE(2), .din0_WIDTH(4), .din1_WIDTH(3),
                       .dout_WIDTH(5), .SAT(1)) u_c (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .din0(din0), .din1(din1), .signed_mode(signed_mode), .out_valid(c_out_valid),
        .out_ready(out_ready), .dout(c_dout), .ovf(c_ovf));

    case_mul_pipe_hs #(.ID(4), .NUM_STAGE(3), .din0_WIDTH(4), .din1_WIDTH(3),
                       .dout_WIDTH(7), .SAT(0)) u_d (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .din0(d_din0), .din1(d_din1), .signed_mode(d_signed_mode), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .dout(d_dout), .ovf(d_ovf));

    // Hand-computed vectors for the shared 2-stage instances (a: 7b wrap, b: 5b wrap, c: 5b sat).
    localparam int N = 7;
    localparam logic [3:0] T_A   [N] = '{4'd9, 4'd9, 4'd7, 4'd15, 4'd14, 4'd9, 4'd9};
    localparam logic [2:0] T_B   [N] = '{3'd3, 3'd3, 3'd3, 3'd7, 3'd3, 3'd3, 3'd3};
    localparam logic       T_M   [N] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [6:0] E_A   [N] = '{7'h6B, 7'h1B, 7'h15, 7'h69, 7'h7A, 7'h6B, 7'h1B};
    localparam logic [4:0] E_B   [N] = '{5'h0B, 5'h1B, 5'h15, 5'h09, 5'h1A, 5'h0B, 5'h1B};
    localparam logic       E_BO  [N] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [4:0] E_C   [N] = '{5'h10, 5'h1B, 5'h0F, 5'h1F, 5'h1A, 5'h10, 5'h1B};

    // Stream for the 3-stage instance.
    localparam logic [3:0] D_A [6] = '{4'd1, 4'd2, 4'd15, 4'd9, 4'd8, 4'd7};
    localparam logic [2:0] D_B [6] = '{3'd1, 3'd3, 3'd7, 3'd3, 3'd4, 3'd4};
    localparam logic       D_M [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [6:0] D_E [6] = '{7'h01, 7'h06, 7'h69, 7'h6B, 7'h20, 7'h64};

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drive_shared(input int k);
        in_valid    = 1'b1;
        din0        = T_A[k];
        din1        = T_B[k];
        signed_mode = T_M[k];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx;
        int  oidx;
        logic acc;

        ap_rst_n      = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b1;
        signed_mode   = 1'b0;
        din0          = '0;
        din1          = '0;
        d_in_valid    = 1'b0;
        d_out_ready   = 1'b1;
        d_signed_mode = 1'b0;
        d_din0        = '0;
        d_din1        = '0;

        #12;
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_dout", a_dout, 0);
        chk("rst_a_ovf", a_ovf, 0);
        chk("rst_a_in_ready", a_in_ready, 1);
        chk("rst_c_dout", c_dout, 0);
        chk("rst_d_out_valid", d_out_valid, 0);
        chk("rst_d_in_ready", d_in_ready, 1);
        ap_rst_n = 1'b1;

        // Isolated signed -7*3: accepted at the first edge after release.
        drive_shared(0);
        tick();
        chk("lat_a_early", a_out_valid, 0);
        in_valid = 1'b0;
        tick();
        chk("lat_a_valid", a_out_valid, 1);
        chk("iso_a_dout", a_dout, E_A[0]);
        chk("iso_a_ovf", a_ovf, 0);
        chk("iso_b_dout", b_dout, E_B[0]);
        chk("iso_b_ovf", b_ovf, 1);
        chk("iso_c_dout", c_dout, E_C[0]);
        chk("iso_c_ovf", c_ovf, 1);
        tick();
        chk("iso_a_drain", a_out_valid, 0);

        // Back-to-back stream with mixed modes, one beat per cycle.
        for (int k = 0; k <= N; k++) begin
            if (k < N) drive_shared(k);
            else in_valid = 1'b0;
            tick();
            if (k == 0) begin
                chk("str_a_first", a_out_valid, 0);
            end else begin
                chk($sformatf("str_a_valid[%0d]", k-1), a_out_valid, 1);
                chk($sformatf("str_a_dout[%0d]", k-1), a_dout, E_A[k-1]);
                chk($sformatf("str_a_ovf[%0d]", k-1), a_ovf, 0);
                chk($sformatf("str_b_dout[%0d]", k-1), b_dout, E_B[k-1]);
                chk($sformatf("str_b_ovf[%0d]", k-1), b_ovf, E_BO[k-1]);
                chk($sformatf("str_c_dout[%0d]", k-1), c_dout, E_C[k-1]);
                chk($sformatf("str_c_ovf[%0d]", k-1), c_ovf, E_BO[k-1]);
            end
        end
        tick();
        chk("str_a_drain", a_out_valid, 0);

        // 3-stage stream with a 4-cycle output stall.
        idx  = 0;
        oidx = 0;
        for (int c = 0; c < 40 && oidx < 6; c++) begin
            d_in_valid = (idx < 6);
            if (idx < 6) begin
                d_din0        = D_A[idx];
                d_din1        = D_B[idx];
                d_signed_mode = D_M[idx];
            end
            d_out_ready = !(c >= 3 && c <= 6);
            #1;
            if (c >= 3 && c <= 6) begin
                chk($sformatf("d_stall_in_ready[%0d]", c), d_in_ready, 0);
                chk($sformatf("d_stall_valid[%0d]", c), d_out_valid, 1);
            end
            if (d_out_valid) begin
                if (oidx < 6) begin
                    chk($sformatf("d_dout[%0d]", oidx), d_dout, D_E[oidx]);
                    chk($sformatf("d_ovf[%0d]", oidx), d_ovf, 0);
                end else begin
                    chk("d_extra_beat", d_out_valid, 0);
                end
                if (d_out_ready) oidx++;
            end
            acc = d_in_valid && d_in_ready;
            tick();
            if (acc) idx++;
        end
        chk("d_all_out", oidx, 6);
        chk("d_all_in", idx, 6);
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        chk("d_drain", d_out_valid, 0);

        // Two beats in flight, then reset for one cycle.
        d_in_valid    = 1'b1;
        d_din0        = 4'd9;
        d_din1        = 3'd3;
        d_signed_mode = 1'b1;
        tick();
        d_din0        = 4'd15;
        d_din1        = 3'd7;
        d_signed_mode = 1'b0;
        tick();
        d_in_valid = 1'b0;
        chk("d_pre_rst_valid", d_out_valid, 0);
        ap_rst_n = 1'b0;
        #1;
        chk("d_rst_out_valid", d_out_valid, 0);
        chk("d_rst_in_ready", d_in_ready, 1);
        chk("d_rst_dout", d_dout, 0);
        tick();
        ap_rst_n      = 1'b1;
        d_in_valid    = 1'b1;
        d_din0        = 4'd7;
        d_din1        = 3'd3;
        d_signed_mode = 1'b0;
        tick();
        d_in_valid = 1'b0;
        chk("d_post_rst_0", d_out_valid, 0);
        tick();
        chk("d_post_rst_1", d_out_valid, 0);
        tick();
        chk("d_post_rst_valid", d_out_valid, 1);
        chk("d_post_rst_dout", d_dout, 7'h15);
        chk("d_post_rst_ovf", d_ovf, 0);
        tick();
        chk("d_post_rst_drain", d_out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/case_mul_pipe_hs.md
CASE_MUL_PIPE_HS -- requirements
Module: case_mul_pipe_hs

Interface
REQ-001 Parameter ID, default 1, instance tag; SHALL have no functional effect.
REQ-002 Parameter NUM_STAGE, default 2, pipeline depth in cycles; legal range 1..8.
REQ-003 Parameter din0_WIDTH, default 14, width of operand A.
REQ-004 Parameter din1_WIDTH, default 12, width of operand B.
REQ-005 Parameter dout_WIDTH, default 26, result width.
REQ-006 Parameter SAT, default 0; 0 = wrap (truncate), 1 = saturate.
REQ-007 ap_clk  input  1  the single clock; all state updates on its rising edge.
REQ-008 ap_rst_n  input  1  asynchronous active-low reset.
REQ-009 in_valid  input  1  operand beat present.
REQ-010 in_ready  output  1  block accepts the beat this cycle.
REQ-011 din0  input  din0_WIDTH  operand A.
REQ-012 din1  input  din1_WIDTH  operand B.
REQ-013 signed_mode  input  1  per-beat mode; 1 = both operands signed, 0 = both unsigned.
REQ-014 out_valid  output  1  result beat present.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 dout  output  dout_WIDTH  result.
REQ-017 ovf  output  1  result did not fit in dout_WIDTH; qualified by out_valid.

Function
REQ-018 Beat accepted when in_valid && in_ready; result emitted when out_valid && out_ready.
REQ-019 Internal advance enable en = !out_valid || out_ready; in_ready SHALL equal en combinationally.
REQ-020 When en=1, every stage (valid bit, operands/product, mode) SHALL shift one place; when en=0, all stages SHALL hold.
REQ-021 Latency: a beat accepted at edge N SHALL appear on dout/out_valid after edge N+NUM_STAGE-1 if no stall; throughput one beat per cycle.
REQ-022 Bubbles (in_valid=0 while en=1) SHALL propagate as invalid stages; results SHALL stay in order.
REQ-023 Full product width P = din0_WIDTH+din1_WIDTH; signed_mode=1 sign-extends both operands, 0 zero-extends.
REQ-024 If dout_WIDTH >= P, dout SHALL be the product extended per mode and ovf SHALL be 0.
REQ-025 If dout_WIDTH < P and SAT=0, dout SHALL be product[dout_WIDTH-1:0]; ovf=1 when discarded bits are not the extension of dout's MSB (signed) or not all zero (unsigned).
REQ-026 If dout_WIDTH < P and SAT=1, out-of-range results SHALL clamp to max/min signed (signed) or all-ones (unsigned), with ovf=1.
REQ-027 Mode, overflow and saturation SHALL be evaluated per beat, so consecutive beats of different mode SHALL each be correct.
REQ-028 out_valid and dout SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 Simultaneous accept and emit in the same cycle with a full pipeline SHALL lose no beat.
REQ-030 dout and ovf values when out_valid=0 are don't-care for checking, but SHALL hold their reset value until the first result.

Reset
REQ-031 ap_rst_n=0 SHALL asynchronously clear all stage valid bits, data and mode registers: out_valid=0, dout=0, ovf=0, in_ready=1.
REQ-032 Assertion mid-operation SHALL discard all in-flight beats; no result SHALL emerge from a beat accepted before reset.
REQ-033 After deassertion, the first accept SHALL be possible in the first clock edge.

Verification
REQ-034 Widths 4/3/7, NUM_STAGE=2: din0=4'b1001, din1=3'b011, signed_mode=1 -> dout=7'b1101011 (-21), ovf=0, one cycle after accept.
REQ-035 Same operands, signed_mode=0 -> dout=7'd27, ovf=0; issuing these alternately with REQ-034 values every cycle -> results alternate -21/27 in order.
REQ-036 Widths 4/3/5, signed_mode=1, -7*3: SAT=0 -> dout=5'b01011, ovf=1; SAT=1 -> dout=5'b10000, ovf=1; unsigned 9*3 with SAT=1 -> 5'b11011, ovf=0.
REQ-037 NUM_STAGE=3, stream 6 beats, hold out_ready=0 for 4 cycles -> in_ready=0 throughout, dout stable, no loss/duplication; all 6 results in order after release.
REQ-038 Accept 2 beats, assert ap_rst_n=0 for 1 cycle mid-flight -> out_valid=0 immediately, neither result appears; a new beat afterwards yields its correct result with nominal latency.
